// File: rtl/gray_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_param
// Description : Parametrised Gray-code counter with up/down stepping, count
//               enable, synchronous clear, parallel Gray load, wrap or
//               saturate mode, registered binary mirror, terminal-count flag
//               and a registered wrap/blocked-step pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter_param #(
    parameter int               WIDTH    = 4,
    parameter int               SATURATE = 0,
    parameter logic [WIDTH-1:0] RST_GRAY = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             tc,
    output logic             evt
);

    // Binary bit i is the XOR of all Gray bits at and above position i.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [WIDTH-1:0] RST_BIN = gray2bin(RST_GRAY);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] BIN_MAX = '1;
    localparam logic [WIDTH-1:0] BIN_MIN = '0;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             evt_q;
    logic             evt_d;
    logic             at_limit;

    // The limit that matters is the one in the currently requested direction.
    assign at_limit = up_dn ? (bin_q == BIN_MAX) : (bin_q == BIN_MIN);

    // Next-state selection: clr beats load beats a counting step.
    always_comb begin
        bin_d = bin_q;
        evt_d = 1'b0;
        if (clr) begin
            bin_d = RST_BIN;
        end else if (load) begin
            bin_d = gray2bin(load_val);
        end else if (en) begin
            if (at_limit) begin
                // Wrap mode moves to the opposite end; saturate mode holds.
                evt_d = 1'b1;
                if (SATURATE == 0) begin
                    bin_d = up_dn ? BIN_MIN : BIN_MAX;
                end
            end else begin
                bin_d = up_dn ? (bin_q + ONE) : (bin_q - ONE);
            end
        end
    end

    // Gray code is derived from the next binary value so both outputs register together.
    assign gray_d = bin_d ^ (bin_d >> 1);

    // State and output registers, cleared asynchronously to the reset code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            evt_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            evt_q  <= evt_d;
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign evt      = evt_q;
    assign tc       = en & ~clr & ~load & at_limit;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_counter_param
// Description : Self-checking bench for gray_counter_param. Three instances
//               (4-bit wrap, 4-bit saturate, 8-bit wrap) share the control
//               inputs and are compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up_dn, clr, load;
    logic [3:0] lv4;
    logic [7:0] lv8;

    logic [3:0] g_w4, b_w4, g_s4, b_s4;
    logic [7:0] g_w8, b_w8;
    logic       tc_w4, tc_s4, tc_w8, ev_w4, ev_s4, ev_w8;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: plain integer count value plus expected pulse.
    int m4, ms4, m8;
    bit e4, es4, e8;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .SATURATE(0), .RST_GRAY(4'b0000)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv4), .gray_out(g_w4), .bin_out(b_w4), .tc(tc_w4), .evt(ev_w4)
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1), .RST_GRAY(4'b0000)) u_s4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv4), .gray_out(g_s4), .bin_out(b_s4), .tc(tc_s4), .evt(ev_s4)
    );

    gray_counter_param #(.WIDTH(8), .SATURATE(0), .RST_GRAY(8'h00)) u_w8 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(lv8), .gray_out(g_w8), .bin_out(b_w8), .tc(tc_w8), .evt(ev_w8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g, input int w);
        int acc = 0;
        int r   = 0;
        for (int i = w - 1; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            r   = r | (acc << i);
        end
        return r;
    endfunction

    // One clock edge of the reference counter for a given width and mode.
    function automatic int step(input int b, input int w, input bit sat, input int lv, output bit ev);
        int top = (1 << w) - 1;
        ev = 1'b0;
        if (clr) return 0;
        if (load) return g2b(lv, w);
        if (!en) return b;
        if (up_dn) begin
            if (b == top) begin ev = 1'b1; return sat ? b : 0; end
            return b + 1;
        end
        if (b == 0) begin ev = 1'b1; return sat ? b : top; end
        return b - 1;
    endfunction

    function automatic bit tcm(input int b, input int w);
        return en && !clr && !load && (up_dn ? (b == (1 << w) - 1) : (b == 0));
    endfunction

    task automatic chk_outputs();
        chk("gray_w4", g_w4, b2g(m4));  chk("bin_w4", b_w4, m4);  chk("evt_w4", ev_w4, e4);
        chk("gray_s4", g_s4, b2g(ms4)); chk("bin_s4", b_s4, ms4); chk("evt_s4", ev_s4, es4);
        chk("gray_w8", g_w8, b2g(m8));  chk("bin_w8", b_w8, m8);  chk("evt_w8", ev_w8, e8);
    endtask

    // Check tc against current inputs, take one edge, advance model, check outputs.
    task automatic cycle();
        #1;
        chk("tc_w4", tc_w4, tcm(m4, 4));
        chk("tc_s4", tc_s4, tcm(ms4, 4));
        chk("tc_w8", tc_w8, tcm(m8, 8));
        @(posedge clk);
        m4  = step(m4,  4, 1'b0, int'(lv4), e4);
        ms4 = step(ms4, 4, 1'b1, int'(lv4), es4);
        m8  = step(m8,  8, 1'b0, int'(lv8), e8);
        #1;
        chk_outputs();
    endtask

    // Pulse reset between edges; outputs must clear without a clock.
    task automatic areset();
        rst = 1'b1;
        #1;
        chk("arst_gray_w4", g_w4, 0);
        chk("arst_bin_w4", b_w4, 0);
        m4 = 0; ms4 = 0; m8 = 0; e4 = 0; es4 = 0; e8 = 0;
        chk_outputs();
        rst = 1'b0;
    endtask

    logic [3:0] walk [16];
    logic [3:0] prev;

    initial begin
        walk = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        rst = 1'b1; en = 0; up_dn = 1; clr = 0; load = 0; lv4 = '0; lv8 = '0;
        m4 = 0; ms4 = 0; m8 = 0; e4 = 0; es4 = 0; e8 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gray", g_w4, 0);
        chk("reset_bin", b_w4, 0);
        chk("reset_evt", ev_w4, 0);
        chk_outputs();
        rst = 1'b0;

        // Full upward walk including the wrap step.
        en = 1; up_dn = 1;
        for (int i = 0; i < 16; i++) begin
            prev = g_w4;
            #1;
            chk("walk_tc", tc_w4, (i == 15));
            cycle();
            chk("walk_gray", g_w4, walk[(i + 1) % 16]);
            chk("walk_bin", b_w4, (i + 1) % 16);
            chk("walk_evt", ev_w4, (i == 15));
            chk("walk_onebit", $countones(prev ^ g_w4), 1);
        end
        en = 0;
        cycle();
        chk("walk_evt_drop", ev_w4, 0);

        // Downward step from reset wraps to the top.
        areset();
        en = 1; up_dn = 0;
        #1;
        chk("down_tc", tc_w4, 1);
        cycle();
        chk("down_gray", g_w4, 4'b1000);
        chk("down_bin", b_w4, 15);
        chk("down_evt", ev_w4, 1);
        en = 0;
        cycle();
        chk("down_evt_drop", ev_w4, 0);

        // Parallel load then single steps either way.
        load = 1; lv4 = 4'b1011; lv8 = 8'h5A;
        cycle();
        chk("load_gray", g_w4, 4'b1011);
        chk("load_bin", b_w4, 13);
        load = 0; en = 1; up_dn = 1;
        cycle();
        chk("load_up_gray", g_w4, 4'b1001);
        chk("load_up_bin", b_w4, 14);
        up_dn = 0;
        cycle();
        chk("load_dn_gray", g_w4, 4'b1011);
        chk("load_dn_bin", b_w4, 13);

        // Saturation at the top end.
        load = 1; lv4 = 4'b1000; en = 0;
        cycle();
        chk("sat_load", g_s4, 4'b1000);
        load = 0; en = 1; up_dn = 1;
        repeat (3) begin
            cycle();
            chk("sat_hold_gray", g_s4, 4'b1000);
            chk("sat_hold_evt", ev_s4, 1);
        end
        up_dn = 0;
        cycle();
        chk("sat_rev_gray", g_s4, 4'b1001);
        chk("sat_rev_bin", b_s4, 14);
        chk("sat_rev_evt", ev_s4, 0);

        // Clear outranks load.
        clr = 1; load = 1; lv4 = 4'b0110; lv8 = 8'h66;
        cycle();
        chk("clr_load_w4", g_w4, 0);
        chk("clr_load_s4", g_s4, 0);
        clr = 0; load = 0;

        // Asynchronous reset in the middle of a count.
        en = 1; up_dn = 1;
        repeat (5) cycle();
        chk("mid_gray", g_w4, 4'b0111);
        areset();
        cycle();
        chk("resume1", g_w4, 4'b0001);
        cycle();
        chk("resume2", g_w4, 4'b0011);

        // Random traffic, loads biased toward the range ends.
        for (int n = 0; n < 10000; n++) begin
            en    = ($urandom_range(0, 3) != 0);
            up_dn = $urandom_range(0, 1);
            clr   = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 15) == 0);
            lv4   = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       lv8 = 8'h80;
                1:       lv8 = 8'h00;
                2:       lv8 = 8'h81;
                default: lv8 = 8'($urandom);
            endcase
            if ($urandom_range(0, 999) == 0) areset();
            cycle();
            chk("gray_rel_w8", g_w8, b_w8 ^ (b_w8 >> 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised synchronous Gray-code counter; successor to the fixed 4-bit SR-flop Gray counter.
- WIDTH is configurable. Supports up/down counting, count enable, synchronous clear and parallel load of a Gray value.
- Mode selects wrap-around or saturating counting. Provides a binary mirror output, a terminal-count flag and a registered wrap/saturation pulse.
- Used as a pointer source for clock-domain-crossing FIFOs and as a low-glitch position counter in the counter library.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2 to 16.
- SATURATE, 0: 0 = wrap at the range ends; 1 = hold at the range ends.
- RST_GRAY, 0, Gray-coded value loaded by reset and by clr; must be a legal WIDTH-bit value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; a step occurs only when en=1.
- up_dn  input  1  direction: 1 = increment, 0 = decrement, in Gray sequence order.
- clr  input  1  synchronous clear to RST_GRAY.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  Gray-coded value applied on load.
- gray_out  output  WIDTH  registered Gray count.
- bin_out  output  WIDTH  binary equivalent of gray_out; registered, same cycle as gray_out.
- tc  output  1  terminal count.
- evt  output  1  one-cycle registered pulse on a wrap (SATURATE=0) or a blocked step (SATURATE=1).

Behaviour:
- State:
  - Internal binary register b.
  - gray_out = registered (b_next ^ (b_next>>1)).
  - bin_out = registered b_next.
  - No combinational path from inputs to gray_out or bin_out.
- Reset (rst=1, asynchronous):
  - gray_out = RST_GRAY; bin_out = Gray-to-binary of RST_GRAY; evt = 0.
  - Takes effect immediately, mid-count included. The first edge after deassertion follows the normal rules.
- Priority per rising edge: clr > load > en-step > hold.
  - clr: state = RST_GRAY; evt = 0.
  - load: b = gray2bin(load_val), with bit i = XOR of load_val[WIDTH-1:i]; evt = 0. en is ignored that cycle.
  - Step up: b+1 modulo 2^WIDTH. Step down: b-1 modulo 2^WIDTH.
  - Hold when en=0: state and outputs unchanged; evt = 0.
- Latency: one clock from input sampling to the updated outputs.
- Gray property: every en-step changes exactly one bit of gray_out, the wrap step included.
  - clr and load may change multiple bits.
- Range ends:
  - up limit: b = 2^WIDTH-1, gray = 1 followed by WIDTH-1 zeros.
  - down limit: b = 0.
- tc is combinational from registered state plus inputs: tc = en & ~clr & ~load & (at the limit in the direction given by up_dn).
- SATURATE=0: a step from a limit wraps to the opposite end. evt = 1 in the cycle after the wrap edge.
- SATURATE=1: a step requested at a limit is blocked; state holds. evt = 1 in the cycle after each blocked edge.
  - Repeated blocked steps give evt high continuously.
- Direction reversal at any point is legal and takes effect on the same edge.
- Simultaneous clr and load: clr wins.
- load_val is always legal, since every WIDTH-bit pattern is a valid Gray code.

Test Plan:
- WIDTH=4, SATURATE=0, reset then en=1, up_dn=1 for 16 edges -> gray_out walks 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000 then back to 0000; bin_out follows 0..15,0. Checker confirms one bit changes per step. tc=1 only while at 1000; evt=1 for exactly one cycle after the 1000->0000 edge.
- Down count from reset with up_dn=0 -> next gray_out=1000, bin_out=15; tc=1 during the cycle at 0000; evt pulses once.
- load=1, load_val=1011 -> next cycle gray_out=1011, bin_out=13. Then one up step -> 1001 (14). Then a down step -> 1011 (13).
- SATURATE=1: load 1000, hold en=1, up_dn=1 for 3 edges -> gray_out stays 1000, evt high for 3 cycles. Then up_dn=0 -> 1001, evt=0.
- clr and load asserted together with load_val=0110 -> gray_out=RST_GRAY (0000).
- Assert rst asynchronously mid-count at gray 0111 -> outputs are 0000 before the next clock edge. After release, counting resumes 0001, 0011.
- WIDTH=8 random en/up_dn/load for 10k cycles -> gray_out == bin_out ^ (bin_out>>1) on every cycle, and the scoreboard matches the reference model.
